// File: rtl/mem_access.sv
// Memory-access pipeline stage with a single-outstanding data-bus master.
// Decodes load/store ops from EX/MEM, issues a registered word-aligned bus
// request with big-endian byte lanes, and returns extended load data to MEM/WB.
// Ports:
//   clk, rst_                 clock, synchronous active-high reset
//   mem_i_op/waddr/wreg/...   EX/MEM pipeline inputs
//   mem_o_waddr/wreg/wdata    MEM/WB pipeline outputs (combinational)
//   stall_req                 freezes upstream pipeline while a transfer is open
//   dbus_*                    data bus request (registered) and response
//   exc_align, exc_bus        misaligned access / ack timeout, single-cycle
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [3:0]  mem_i_op,
    input  logic [4:0]  mem_i_waddr,
    input  logic        mem_i_wreg,
    input  logic [31:0] mem_i_wdata,
    input  logic [31:0] mem_i_maddr,
    input  logic [31:0] mem_i_sdata,
    output logic [4:0]  mem_o_waddr,
    output logic        mem_o_wreg,
    output logic [31:0] mem_o_wdata,
    output logic        stall_req,
    output logic [31:0] dbus_addr,
    output logic        dbus_stb,
    output logic        dbus_we,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        exc_align,
    output logic        exc_bus
);

    // Counter only has to reach ACK_TIMEOUT-1; with timeout disabled it may wrap.
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        bwdata_q, bwdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdat_q, rdat_d;
    logic               err_q, err_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         off_q, off_d;

    // Decode of the incoming op
    logic        is_b, is_h, is_w, is_st, is_mem, misal;
    logic [3:0]  sel_new;
    logic [31:0] sdata_new;

    always_comb begin
        is_b  = (mem_i_op == OP_LB) || (mem_i_op == OP_LBU) || (mem_i_op == OP_SB);
        is_h  = (mem_i_op == OP_LH) || (mem_i_op == OP_LHU) || (mem_i_op == OP_SH);
        is_w  = (mem_i_op == OP_LW) || (mem_i_op == OP_SW);
        is_st = (mem_i_op == OP_SB) || (mem_i_op == OP_SH) || (mem_i_op == OP_SW);
        is_mem = is_b || is_h || is_w;
        misal = (is_h && mem_i_maddr[0]) || (is_w && (mem_i_maddr[1:0] != 2'b00));

        sel_new   = 4'b1111;
        sdata_new = mem_i_sdata;
        if (is_b) begin
            sel_new   = 4'b1000 >> mem_i_maddr[1:0];
            sdata_new = {4{mem_i_sdata[7:0]}};
        end else if (is_h) begin
            sel_new   = mem_i_maddr[1] ? 4'b0011 : 4'b1100;
            sdata_new = {2{mem_i_sdata[15:0]}};
        end
    end

    // Lane extraction of returned read data for the latched op/offset
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        op_q_is_load;

    always_comb begin
        ld_byte = dbus_rdata[31:24];
        unique case (off_q)
            2'd0: ld_byte = dbus_rdata[31:24];
            2'd1: ld_byte = dbus_rdata[23:16];
            2'd2: ld_byte = dbus_rdata[15:8];
            2'd3: ld_byte = dbus_rdata[7:0];
            default: ld_byte = dbus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];

        ld_val = 32'd0;
        case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'd0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'd0, ld_half};
            OP_LW:   ld_val = dbus_rdata;
            default: ld_val = 32'd0;
        endcase

        op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
    end

    // Next-state and outputs
    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        bwdata_d = bwdata_q;
        cnt_d    = cnt_q;
        rdat_d   = rdat_q;
        err_d    = err_q;
        op_d     = op_q;
        off_d    = off_q;

        mem_o_wreg  = 1'b0;
        mem_o_wdata = mem_i_wdata;
        stall_req   = 1'b0;
        exc_align   = 1'b0;
        exc_bus     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!is_mem) begin
                    mem_o_wreg = mem_i_wreg;
                end else if (misal) begin
                    exc_align = 1'b1;
                end else begin
                    stall_req = 1'b1;
                    state_d   = S_BUSY;
                    stb_d     = 1'b1;
                    we_d      = is_st;
                    sel_d     = sel_new;
                    addr_d    = {mem_i_maddr[31:2], 2'b00};
                    bwdata_d  = sdata_new;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    op_d      = mem_i_op;
                    off_d     = mem_i_maddr[1:0];
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                // Ack wins over a coincident timeout
                if (dbus_ack) begin
                    rdat_d  = ld_val;
                    state_d = S_DONE;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end else if ((ACK_TIMEOUT != 32'd0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (err_q) begin
                    exc_bus = 1'b1;
                end else if (op_q_is_load) begin
                    mem_o_wreg  = mem_i_wreg;
                    mem_o_wdata = rdat_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pipeline-facing controls are forced quiet while reset is held
        if (rst_) begin
            mem_o_wreg = 1'b0;
            stall_req  = 1'b0;
            exc_align  = 1'b0;
            exc_bus    = 1'b0;
        end
    end

    // State and bus registers
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q  <= S_IDLE;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            addr_q   <= 32'd0;
            bwdata_q <= 32'd0;
            cnt_q    <= '0;
            rdat_q   <= 32'd0;
            err_q    <= 1'b0;
            op_q     <= 4'd0;
            off_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            bwdata_q <= bwdata_d;
            cnt_q    <= cnt_d;
            rdat_q   <= rdat_d;
            err_q    <= err_d;
            op_q     <= op_d;
            off_q    <= off_d;
        end
    end

    assign mem_o_waddr = mem_i_waddr;
    assign dbus_addr   = addr_q;
    assign dbus_stb    = stb_q;
    assign dbus_we     = we_q;
    assign dbus_sel    = sel_q;
    assign dbus_wdata  = bwdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus randomized ops against a
// behavioural model of sizes, lanes, alignment and timeout rules.
module tb_mem_access;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_;
    logic [3:0]  mem_i_op;
    logic [4:0]  mem_i_waddr;
    logic        mem_i_wreg;
    logic [31:0] mem_i_wdata, mem_i_maddr, mem_i_sdata;
    logic [4:0]  mem_o_waddr;
    logic        mem_o_wreg;
    logic [31:0] mem_o_wdata;
    logic        stall_req;
    logic [31:0] dbus_addr;
    logic        dbus_stb, dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata, dbus_rdata;
    logic        dbus_ack;
    logic        exc_align, exc_bus;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mem_access #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_(rst_),
        .mem_i_op(mem_i_op), .mem_i_waddr(mem_i_waddr), .mem_i_wreg(mem_i_wreg),
        .mem_i_wdata(mem_i_wdata), .mem_i_maddr(mem_i_maddr), .mem_i_sdata(mem_i_sdata),
        .mem_o_waddr(mem_o_waddr), .mem_o_wreg(mem_o_wreg), .mem_o_wdata(mem_o_wdata),
        .stall_req(stall_req),
        .dbus_addr(dbus_addr), .dbus_stb(dbus_stb), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .exc_align(exc_align), .exc_bus(exc_bus)
    );

    // Runs one op from IDLE to back in IDLE. ack_at = BUSY cycle (1-based)
    // in which ack is raised; 0 or > TMO means no ack before the timeout.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] maddr,
                          input logic [31:0] sdata, input logic wreg, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rdata, input int exp_stall);
        int unsigned size, off, shift;
        logic        none_op, store, sgn, mis, ok;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata, e_load, mask;
        logic [8:0]  e_idle, g_idle;
        logic [5:0]  e_bus, g_bus;
        logic [4:0]  e_done, g_done;
        logic [4:0]  waddr;
        int          stall_cnt;
        logic        got;

        none_op = (op == 4'd0) || (op > 4'd8);
        store   = (op >= 4'd6) && (op <= 4'd8);
        sgn     = (op == 4'd1) || (op == 4'd3);
        size    = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 1 :
                  (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 : 4;
        off     = maddr % 4;
        mis     = !none_op && ((maddr % size) != 0);
        e_sel   = 4'(((1 << size) - 1) << (4 - size - off));
        e_wdata = (size == 1) ? sdata[7:0] * 32'h01010101 :
                  (size == 2) ? sdata[15:0] * 32'h00010001 : sdata;
        shift   = 8 * (4 - size - off);
        mask    = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
        e_load  = (rdata >> shift) & mask;
        if (sgn && ((e_load >> (8 * size - 1)) & 32'd1) == 32'd1) e_load = e_load | ~mask;
        ok      = (ack_at >= 1) && (ack_at <= int'(TMO));
        waddr   = 5'($urandom);
        stall_cnt = 0;

        mem_i_op = op; mem_i_maddr = maddr; mem_i_sdata = sdata;
        mem_i_wreg = wreg; mem_i_wdata = wdata; mem_i_waddr = waddr;
        dbus_rdata = rdata; dbus_ack = 1'b0;
        #1;
        // IDLE: {stall, wreg, exc_align, exc_bus, waddr}
        if (none_op)  e_idle = {1'b0, wreg, 1'b0, 1'b0, waddr};
        else if (mis) e_idle = {1'b0, 1'b0, 1'b1, 1'b0, waddr};
        else          e_idle = {1'b1, 1'b0, 1'b0, 1'b0, waddr};
        g_idle = {stall_req, mem_o_wreg, exc_align, exc_bus, mem_o_waddr};
        stall_cnt += int'(stall_req);
        n_vec++;
        if (g_idle !== e_idle) begin
            n_err++;
            $display("FAIL %s idle ctl got %b want %b", name, g_idle, e_idle);
        end
        if (none_op) begin
            n_vec++;
            if (mem_o_wdata !== wdata) begin
                n_err++;
                $display("FAIL %s idle wdata got %h want %h", name, mem_o_wdata, wdata);
            end
        end
        if (none_op || mis) begin
            @(posedge clk); #1;
            n_vec++;
            if (dbus_stb !== 1'b0) begin
                n_err++;
                $display("FAIL %s no-transfer stb got %b want 0", name, dbus_stb);
            end
            mem_i_op = 4'd0;
            return;
        end

        @(posedge clk); #1;
        got = 1'b0;
        for (int k = 1; k <= int'(TMO); k++) begin
            dbus_ack = (k == ack_at);
            #1;
            e_bus = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, store};
            g_bus = {stall_req, mem_o_wreg, exc_align, exc_bus, dbus_stb, dbus_we};
            stall_cnt += int'(stall_req);
            n_vec++;
            if (g_bus !== e_bus || dbus_addr !== {maddr[31:2], 2'b00} ||
                dbus_sel !== e_sel || (store && dbus_wdata !== e_wdata)) begin
                n_err++;
                $display("FAIL %s busy%0d ctl %b/%b addr %h/%h sel %b/%b wdata %h/%h (got/want)",
                         name, k, g_bus, e_bus, dbus_addr, {maddr[31:2], 2'b00},
                         dbus_sel, e_sel, dbus_wdata, e_wdata);
            end
            got = (k == ack_at);
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            if (got) break;
        end

        #1;
        // DONE: {stall, wreg, exc_align, exc_bus, stb}
        e_done = {1'b0, ok && !store && wreg, 1'b0, !ok, 1'b0};
        g_done = {stall_req, mem_o_wreg, exc_align, exc_bus, dbus_stb};
        n_vec++;
        if (g_done !== e_done) begin
            n_err++;
            $display("FAIL %s done ctl got %b want %b", name, g_done, e_done);
        end
        if (ok && !store) begin
            n_vec++;
            if (mem_o_wdata !== e_load) begin
                n_err++;
                $display("FAIL %s load data got %h want %h", name, mem_o_wdata, e_load);
            end
        end
        if (exp_stall >= 0) begin
            n_vec++;
            if (stall_cnt != exp_stall) begin
                n_err++;
                $display("FAIL %s stall cycles got %0d want %0d", name, stall_cnt, exp_stall);
            end
        end
        @(posedge clk); #1;
        mem_i_op = 4'd0;
    endtask

    task automatic test_reset();
        rst_ = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0;
        mem_i_op = 4'd5; mem_i_maddr = 32'h0000_0101; mem_i_sdata = 32'd0;
        mem_i_wreg = 1'b1; mem_i_wdata = 32'h1234_5678; mem_i_waddr = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({stall_req, mem_o_wreg, exc_align, exc_bus} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl got %b want 0000", {stall_req, mem_o_wreg, exc_align, exc_bus});
        end
        n_vec++;
        if ({dbus_stb, dbus_we, dbus_sel, dbus_addr, dbus_wdata} !== 70'd0) begin
            n_err++;
            $display("FAIL reset_bus stb %b we %b sel %b addr %h wdata %h want all 0",
                     dbus_stb, dbus_we, dbus_sel, dbus_addr, dbus_wdata);
        end
        rst_ = 1'b0; mem_i_op = 4'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        mem_i_op = 4'd1; mem_i_maddr = 32'h0000_0040; mem_i_wreg = 1'b1;
        dbus_ack = 1'b0; dbus_rdata = 32'hAABB_CCDD;
        @(posedge clk); #1;
        n_vec++;
        if (dbus_stb !== 1'b1) begin
            n_err++;
            $display("FAIL rst_busy enter stb got %b want 1", dbus_stb);
        end
        rst_ = 1'b1;
        #1;
        n_vec++;
        if ({stall_req, mem_o_wreg} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_busy held ctl got %b want 00", {stall_req, mem_o_wreg});
        end
        @(posedge clk); #1;
        rst_ = 1'b0; mem_i_op = 4'd0; mem_i_wreg = 1'b0; dbus_ack = 1'b1;
        #1;
        n_vec++;
        if ({dbus_stb, stall_req, mem_o_wreg, exc_bus} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_busy late_ack got %b want 0000",
                     {dbus_stb, stall_req, mem_o_wreg, exc_bus});
        end
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        n_vec++;
        if ({dbus_stb, stall_req, mem_o_wreg, exc_bus} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_busy no_done got %b want 0000",
                     {dbus_stb, stall_req, mem_o_wreg, exc_bus});
        end
    endtask

    task automatic test_directed();
        run_op("lb_signext", 4'd1, 32'h0000_1001, 32'd0, 1'b1, 32'd0, 1, 32'h12F4_5678, 2);
        run_op("sh_3cyc",    4'd7, 32'h0000_2002, 32'h0000_BEEF, 1'b1, 32'd0, 3, 32'd0, 4);
        run_op("lw_misal",   4'd5, 32'h0000_3002, 32'd0, 1'b1, 32'd0, 1, 32'd0, 0);
        run_op("lhu_tmo",    4'd4, 32'h0000_4000, 32'd0, 1'b1, 32'd0, 0, 32'h8765_4321, 5);
        run_op("none_pass",  4'd0, 32'h0000_0003, 32'd0, 1'b1, 32'hCAFE_BABE, 1, 32'd0, 0);
        run_op("ack_at_tmo", 4'd3, 32'h0000_5002, 32'd0, 1'b1, 32'd0, 4, 32'h0000_8001, 5);
        run_op("sb_lane3",   4'd6, 32'h0000_6003, 32'h0000_00A5, 1'b0, 32'd0, 2, 32'd0, 3);
        run_op("op_15_none", 4'd15, 32'h0000_0001, 32'd0, 1'b1, 32'h0BAD_F00D, 1, 32'd0, 0);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 300; i++) begin
            op   = 4'($urandom_range(0, 15));
            if (op > 4'd8 && ($urandom_range(0, 3) != 0)) op = 4'($urandom_range(1, 8));
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            run_op("rand", op, addr, $urandom, 1'($urandom), $urandom,
                   $urandom_range(0, 5), $urandom, -1);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_lw",  4'd5, 32'h0000_7000, 32'd0, 1'b1, 32'd0, 1, 32'hDEAD_BEEF, 2);
        run_op("b2b_sw",  4'd8, 32'h0000_7004, 32'h0102_0304, 1'b1, 32'd0, 1, 32'd0, 2);
        run_op("b2b_lbu", 4'd2, 32'h0000_7002, 32'd0, 1'b1, 32'd0, 2, 32'h00FF_8000, 3);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
